// File: rtl/mem_ctrl_array_if.sv
// Request/response bus of mem_ctrl_array. The requester drives the master side.
interface mem_ctrl_array_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              select;
   logic              op;
   logic              clr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic              rw;
   logic              err;
   logic              busy;

   modport master (output select, op, clr, addr, din,
                   input  dout, valid, rw, err, busy);
   modport slave  (input  select, op, clr, addr, din,
                   output dout, valid, rw, err, busy);
endinterface

// File: rtl/mem_ctrl_array.sv
// DEPTH x DATA_W word memory with per-word written tracking, bulk clear and range checking.
// A request is accepted only in IDLE, and its response pulse follows two cycles later.
module mem_ctrl_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic            clk,
   input  logic            reset,
   mem_ctrl_array_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP,
      ST_CLEAR
   } state_e;

   state_e            state_q, state_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DEPTH-1:0]  written_q, written_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              rw_q, rw_d;
   logic              err_q, err_d;
   logic              in_range;
   logic              mem_we;
   logic [DATA_W-1:0] mem [DEPTH];

   assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));

   always_comb begin
      // NOTE: every _d signal gets a default first, so no path through this block infers a latch.
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      din_d     = din_q;
      written_d = written_q;
      dout_d    = '0;
      valid_d   = 1'b0;
      rw_d      = 1'b0;
      err_d     = 1'b0;
      mem_we    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // clr wins over select; a select in the same cycle is dropped.
            if (bus.clr) begin
               state_d = ST_CLEAR;
            end else if (bus.select) begin
               state_d = ST_ACCESS;
               op_d    = bus.op;
               addr_d  = bus.addr;
               din_d   = bus.din;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            rw_d    = op_q;
            if (!in_range) begin
               err_d = 1'b1;
            end else if (op_q) begin
               mem_we            = 1'b1;
               written_d[addr_q] = 1'b1;
            end else if (!written_q[addr_q]) begin
               err_d = 1'b1;
            end else begin
               dout_d = mem[addr_q];
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         ST_CLEAR: begin
            state_d   = ST_IDLE;
            written_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         written_q <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         rw_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         written_q <= written_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         rw_q      <= rw_d;
         err_q     <= err_d;
      end
   end

   // NOTE: storage has no reset; the written bits alone decide whether a word's contents are valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr_q] <= din_q;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
   assign bus.rw    = rw_q;
   assign bus.err   = err_q;
   assign bus.busy  = (state_q != ST_IDLE);
endmodule

// File: doc/mem_ctrl_array.md
Name: mem_ctrl_array

Overview:
- Parametrised successor to the 8x8 word memory.
- Synchronous DEPTH x DATA_W storage array fronted by a request/response state machine.
- Request (select, op, addr, din) accepted only in IDLE; response (valid, dout, err) returned two cycles later.
- Adds per-word written tracking, a bulk clear command, out-of-range address detection and an explicit busy indication.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 3, address width in bits.
- DEPTH, 8, number of words; DEPTH <= 2**ADDR_W and DEPTH >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- select  input  1  request strobe, sampled in IDLE only.
- op  input  1  1 = write, 0 = read; sampled with select.
- clr  input  1  bulk clear request, sampled in IDLE only.
- addr  input  ADDR_W  word address, sampled with select.
- din  input  DATA_W  write data, sampled with select.
- dout  output  DATA_W  read data; meaningful only while valid=1.
- valid  output  1  one-cycle response pulse.
- rw  output  1  op of the request being responded to; qualified by valid.
- err  output  1  response error flag; qualified by valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all word-written bits cleared.
  - dout=0, valid=0, rw=0, err=0, busy=0.
  - Array contents are not reset.
- States:
  - IDLE -> CLEAR when clr=1. clr has priority over select in the same cycle; select is dropped, not queued.
  - IDLE -> ACCESS when clr=0 and select=1. Latches op, addr, din into request registers.
  - ACCESS -> RESP, always, next cycle.
  - RESP -> IDLE, always, next cycle.
  - CLEAR -> IDLE, always, next cycle.
- ACCESS cycle actions:
  - Range check: in_range = (addr_q < DEPTH).
  - Write (op_q=1) and in_range: mem[addr_q] <= din_q; written[addr_q] <= 1.
  - Read (op_q=0) and in_range: rdata <= mem[addr_q]; rhit <= written[addr_q].
- RESP outputs, registered, visible for exactly one cycle:
  - valid=1, rw=op_q.
  - err=1 if out of range, or if the request was a read of a word with written=0.
  - dout = read data for a successful read; 0 for writes and for any err=1 response.
- Outside RESP: valid=0, err=0, dout=0, rw=0.
- Latency:
  - select sampled high at edge N -> valid=1 during cycle N+2.
  - Earliest next accepted request is at edge N+3.
  - Maximum throughput: one request per 3 cycles.
- CLEAR:
  - All written bits go to 0 at the edge leaving CLEAR.
  - Data words are untouched; no valid pulse.
  - busy=1 for that one cycle.
- Inputs during busy=1 are ignored: no queueing, no effect on the in-flight request.
- A write followed immediately by a read of the same address returns the new data; the write has completed before the read's ACCESS cycle.
- Reset asserted mid-operation aborts the request. Any write already committed in ACCESS stays in the array, but its written bit is cleared by reset.
- When DEPTH < 2**ADDR_W, out-of-range addresses never modify storage.

Test Plan:
1. Reset, then write 65, 83, 73, 73, 76 to addresses 0..4, each followed by 2 idle cycles. Expect valid=1, rw=1, err=0 at N+2 for each, and busy=1 for cycles N+1..N+2.
2. Read addresses 0..4 -> dout=65, 83, 73, 73, 76 with err=0. Read address 5 (never written) -> err=1, dout=0.
3. Assert clr in IDLE, then read address 0 -> err=1, dout=0. Write 0x5A to address 0, then read address 0 -> dout=0x5A, err=0.
4. Assert select every cycle while busy with differing addr/din -> only requests sampled in IDLE take effect; exactly one valid per 3 cycles.
5. With DEPTH=6, ADDR_W=3: write address 7 -> err=1. Read address 5 still returns its prior value, confirming no aliasing.
6. Drop reset low during ACCESS of a write to address 2 -> outputs go to 0 immediately and no valid follows. After release, read address 2 -> err=1.
